mio_arbiter: RTL and testbench

Arbitrates one single-port synchronous memory/IO bus between two masters: the multi-cycle CPU and a secondary master (DMA/VGA fetch). Each master gets a request/ready handshake, and the CPU's ready drives its MIO_ready stall input. The block sequences every bus transaction through a fixed-latency access window. CPU has fixed priority, with a starvation guard for the secondary master.

---
 rtl/mio_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mio_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mio_arbiter.sv
// mio_arbiter
//   Shares one single-port synchronous memory/IO bus between the CPU
//   (fixed priority) and a secondary master (DMA/VGA fetch). Every bus
//   transaction runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle
//   ready pulse). A starvation counter forces a DMA grant once the CPU
//   has won STARVE_MAX consecutive arbitrations while dma_req was pending.
//
// Optional build macro: MIO_ARB_STATS_EN
//   defined   : stat_cpu_cnt / stat_dma_cnt count grants (saturating)
//   undefined : both stat ports are tied to 16'h0000
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata      CPU request side
//   cpu_ready, cpu_rdata       CPU completion pulse (MIO_ready) and read data
//   dma_req/we/addr/wdata      secondary master request side
//   dma_ready, dma_rdata       secondary completion pulse and read data
//   mem_en/we/addr/wdata       memory bus command
//   mem_rdata                  memory read data
//   grant                      owner: 01 CPU, 10 DMA, 00 none
//   stat_cpu_cnt, stat_dma_cnt grant statistics
module mio_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic [15:0]       stat_cpu_cnt,
  output logic [15:0]       stat_dma_cnt
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_dma;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_lat;
  logic [3:0]        r_starve;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic w_req_any;
  logic w_pick_dma;
  logic w_grant_now;
  logic w_last;

  assign w_req_any   = cpu_req | dma_req;
  // DMA wins when alone, or when the CPU has starved it STARVE_MAX times.
  assign w_pick_dma  = dma_req & (~cpu_req | (r_starve == STARVE_CAP));
  assign w_grant_now = (r_state == S_IDLE) & w_req_any;
  assign w_last      = (r_state == S_ACCESS) & (r_lat == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    cpu_ready   = 1'b0;
    dma_ready   = 1'b0;
    grant       = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
        grant  = {r_owner_dma, ~r_owner_dma};
        if (r_lat == 4'd0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        cpu_ready   = ~r_owner_dma;
        dma_ready   = r_owner_dma;
        grant       = {r_owner_dma, ~r_owner_dma};
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction latch and access-window countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_dma <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lat       <= 4'd0;
    end else if (w_grant_now) begin
      r_owner_dma <= w_pick_dma;
      r_we        <= w_pick_dma ? dma_we    : cpu_we;
      r_addr      <= w_pick_dma ? dma_addr  : cpu_addr;
      r_wdata     <= w_pick_dma ? dma_wdata : cpu_wdata;
      r_lat       <= LAT_LOAD;
    end else if ((r_state == S_ACCESS) && (r_lat != 4'd0)) begin
      r_lat <= r_lat - 4'd1;
    end
  end

  // Read data is captured on the closing edge of the access window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else if (w_last && !r_we) begin
      if (r_owner_dma) r_dma_rdata <= mem_rdata;
      else             r_cpu_rdata <= mem_rdata;
    end
  end

  // Starvation counter: only IDLE cycles touch it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_req_any && w_pick_dma)   r_starve <= 4'd0;
      else if (w_req_any && dma_req) begin
        if (r_starve != STARVE_CAP)  r_starve <= r_starve + 4'd1;
      end
      else if (!dma_req)             r_starve <= 4'd0;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

`ifdef MIO_ARB_STATS_EN
  logic [15:0] r_stat_cpu;
  logic [15:0] r_stat_dma;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_cpu <= 16'h0000;
      r_stat_dma <= 16'h0000;
    end else if (w_grant_now) begin
      if (w_pick_dma) begin
        if (r_stat_dma != 16'hFFFF) r_stat_dma <= r_stat_dma + 16'd1;
      end else begin
        if (r_stat_cpu != 16'hFFFF) r_stat_cpu <= r_stat_cpu + 16'd1;
      end
    end
  end

  assign stat_cpu_cnt = r_stat_cpu;
  assign stat_dma_cnt = r_stat_dma;
`else
  assign stat_cpu_cnt = 16'h0000;
  assign stat_dma_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mio_arbiter.sv
// Directed bench for mio_arbiter. Instance u_a uses MEM_LAT=1, instance
// u_b uses MEM_LAT=3; both use STARVE_MAX=4 and share clock and reset.
module tb_mio_arbiter;

`ifdef MIO_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A signals
  logic        a_cpu_req, a_cpu_we, a_cpu_ready;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_dma_req, a_dma_we, a_dma_ready;
  logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_grant;
  logic [15:0] a_stat_cpu, a_stat_dma;

  // instance B signals
  logic        b_cpu_req, b_cpu_we, b_cpu_ready;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_dma_req, b_dma_we, b_dma_ready;
  logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_grant;
  logic [15:0] b_stat_cpu, b_stat_dma;

  mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_ready(a_cpu_ready), .cpu_rdata(a_cpu_rdata),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr),
    .dma_wdata(a_dma_wdata), .dma_ready(a_dma_ready), .dma_rdata(a_dma_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .grant(a_grant),
    .stat_cpu_cnt(a_stat_cpu), .stat_dma_cnt(a_stat_dma)
  );

  mio_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_ready(b_cpu_ready), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr),
    .dma_wdata(b_dma_wdata), .dma_ready(b_dma_ready), .dma_rdata(b_dma_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .grant(b_grant),
    .stat_cpu_cnt(b_stat_cpu), .stat_dma_cnt(b_stat_dma)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; return 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected grant pattern for the starvation run
  logic [1:0]  exp_grant [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

  initial begin
    reset = 1'b1;
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0;
    a_mem_rdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
    b_mem_rdata = 0;
    tick();
    tick();

    // reset state
    check_eq("rst_a_grant", a_grant, 2'b00);
    check_eq("rst_a_mem_en", a_mem_en, 0);
    check_eq("rst_a_mem_we", a_mem_we, 0);
    check_eq("rst_a_ready", {a_cpu_ready, a_dma_ready}, 0);
    check_eq("rst_a_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
    check_eq("rst_a_stats", {a_stat_cpu, a_stat_dma}, 0);
    check_eq("rst_b_grant", b_grant, 2'b00);
    check_eq("rst_b_mem_addr", b_mem_addr, 0);
    reset = 1'b0;
    tick();
    check_eq("idle_a_mem_en", a_mem_en, 0);

    // CPU read, MEM_LAT=1
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'h0000_0010; a_mem_rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("rd_access_en", a_mem_en, 1);
    check_eq("rd_access_we", a_mem_we, 0);
    check_eq("rd_access_addr", a_mem_addr, 32'h10);
    check_eq("rd_access_grant", a_grant, 2'b01);
    check_eq("rd_access_ready", a_cpu_ready, 0);
    tick();
    check_eq("rd_resp_ready", a_cpu_ready, 1);
    check_eq("rd_resp_en", a_mem_en, 0);
    check_eq("rd_resp_grant", a_grant, 2'b01);
    check_eq("rd_rdata", a_cpu_rdata, 32'hDEAD_BEEF);
    a_cpu_req = 0;
    tick();
    check_eq("rd_idle_ready", a_cpu_ready, 0);
    check_eq("rd_idle_grant", a_grant, 2'b00);

    // req held across RESP: two back-to-back CPU reads
    a_cpu_req = 1; a_cpu_addr = 32'h20; a_mem_rdata = 32'h1111_1111;
    tick();
    check_eq("hold1_access_en", a_mem_en, 1);
    tick();
    check_eq("hold1_ready", a_cpu_ready, 1);
    check_eq("hold1_rdata", a_cpu_rdata, 32'h1111_1111);
    a_mem_rdata = 32'h2222_2222;
    tick();
    check_eq("hold_idle_en", a_mem_en, 0);
    check_eq("hold_idle_grant", a_grant, 2'b00);
    check_eq("hold_idle_ready", a_cpu_ready, 0);
    tick();
    check_eq("hold2_access_en", a_mem_en, 1);
    check_eq("hold2_access_grant", a_grant, 2'b01);
    tick();
    check_eq("hold2_ready", a_cpu_ready, 1);
    check_eq("hold2_rdata", a_cpu_rdata, 32'h2222_2222);
    a_cpu_req = 0;
    tick();
    check_eq("stat_cpu_3", a_stat_cpu, STATS ? 16'd3 : 16'd0);
    check_eq("stat_dma_0", a_stat_dma, 16'd0);

    // DMA read on A
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 32'h80; a_mem_rdata = 32'hCAFE_0001;
    tick();
    check_eq("dmard_grant", a_grant, 2'b10);
    check_eq("dmard_addr", a_mem_addr, 32'h80);
    tick();
    check_eq("dmard_ready", {a_cpu_ready, a_dma_ready}, 2'b01);
    check_eq("dmard_rdata", a_dma_rdata, 32'hCAFE_0001);
    check_eq("dmard_cpu_rdata_kept", a_cpu_rdata, 32'h2222_2222);
    a_dma_req = 0;
    tick();

    // starvation: both requests held high continuously
    a_cpu_req = 1; a_cpu_addr = 32'h100; a_dma_req = 1; a_dma_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      a_mem_rdata = 32'h5000_0000 + i;
      tick();
      check_eq($sformatf("starve_grant_%0d", i), a_grant, exp_grant[i]);
      tick();
      check_eq($sformatf("starve_ready_%0d", i), {a_dma_ready, a_cpu_ready}, exp_grant[i]);
      if (i == 5) begin a_cpu_req = 0; a_dma_req = 0; end
      tick();
    end
    check_eq("starve_dma_rdata", a_dma_rdata, 32'h5000_0004);
    check_eq("starve_cpu_rdata", a_cpu_rdata, 32'h5000_0005);
    check_eq("stat_cpu_final", a_stat_cpu, STATS ? 16'd8 : 16'd0);
    check_eq("stat_dma_final", a_stat_dma, STATS ? 16'd2 : 16'd0);

    // B: DMA read to preload dma_rdata, MEM_LAT=3
    b_dma_req = 1; b_dma_we = 0; b_dma_addr = 32'h30; b_mem_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 3; i++) tick();
    tick();
    check_eq("b_dmard_ready", b_dma_ready, 1);
    check_eq("b_dmard_rdata", b_dma_rdata, 32'hA5A5_A5A5);
    b_dma_req = 0;
    tick();

    // B: DMA write, MEM_LAT=3
    b_dma_req = 1; b_dma_we = 1; b_dma_addr = 32'h40; b_dma_wdata = 32'h1234_5678;
    b_mem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("wr_acc%0d_en_we", i), {b_mem_en, b_mem_we}, 2'b11);
      check_eq($sformatf("wr_acc%0d_addr", i), b_mem_addr, 32'h40);
      check_eq($sformatf("wr_acc%0d_wdata", i), b_mem_wdata, 32'h1234_5678);
      check_eq($sformatf("wr_acc%0d_grant", i), b_grant, 2'b10);
      check_eq($sformatf("wr_acc%0d_ready", i), {b_cpu_ready, b_dma_ready}, 0);
    end
    tick();
    check_eq("wr_resp_ready", {b_cpu_ready, b_dma_ready}, 2'b01);
    check_eq("wr_resp_en", b_mem_en, 0);
    check_eq("wr_rdata_kept", b_dma_rdata, 32'hA5A5_A5A5);
    b_dma_req = 0; b_dma_we = 0;
    tick();
    check_eq("wr_idle_ready", b_dma_ready, 0);

    // B: reset in the 2nd ACCESS cycle of a CPU write
    b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 32'h50; b_cpu_wdata = 32'h55;
    tick();
    tick();
    check_eq("rstmid_pre_we", b_mem_we, 1);
    reset = 1'b1;
    #1;
    check_eq("rstmid_en_we", {b_mem_en, b_mem_we}, 0);
    check_eq("rstmid_grant", b_grant, 2'b00);
    check_eq("rstmid_ready", b_cpu_ready, 0);
    b_cpu_req = 0; b_cpu_we = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("rstmid_after%0d", i), {b_cpu_ready, b_mem_en, b_grant}, 0);
    end
    check_eq("rst_clears_stats", {a_stat_cpu, a_stat_dma}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
